johnson_decoder: RTL and testbench

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_pkg.sv | 13 +
 rtl/johnson_code_check.sv | 40 ++++
 rtl/johnson_decoder.sv | 155 +++++++++++++++
 tb/tb_johnson_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-code decoder: FSM state encoding,
// default code width and error counter width.
package johnson_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int ERR_CNT_W = 8;

   typedef enum logic [0:0] {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson code legality test and sequence-index decode.
// A legal word has at most one boundary between adjacent differing bits.
// Index is the popcount when bit 0 is set (filling phase), 0 for all-zeros,
// and 2*WIDTH - popcount otherwise (draining phase). The index of an
// illegal word is meaningless and must be qualified by legal_o.
module johnson_code_check
   import johnson_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDX_W = $clog2(2*WIDTH)
) (
   input  logic [WIDTH-1:0] code_i,
   output logic             legal_o,
   output logic [IDX_W-1:0] index_o
);

   // count adjacent-bit transitions and ones, then decode
   always_comb begin
      int trans;
      int ones;
      trans   = 0;
      ones    = 0;
      legal_o = 1'b0;
      index_o = '0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (code_i[i] != code_i[i+1]) trans++;
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (code_i[i]) ones++;
      end
      legal_o = (trans <= 1);
      if (code_i[0])
         index_o = IDX_W'(ones);
      else if (ones == 0)
         index_o = '0;
      else
         index_o = IDX_W'(2*WIDTH - ones);
   end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code decoder with step checking and lock detection.
// Optional feature macro: JOHNSON_DECODER_BIDIR_EN -- when defined, a
// step to (p-1) mod 2*WIDTH is accepted and reported with dir=1; when
// undefined, down steps are step errors and dir stays 0.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   SEARCH | counting consecutive good steps toward LOCK_CNT
//   LOCKED | stream tracking; any illegal/step error counts and drops out
module johnson_decoder
   import johnson_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int LOCK_CNT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH-1:0]              code_in,
   input  logic                          code_valid,
   output logic [$clog2(2*WIDTH)-1:0]    index,
   output logic                          index_valid,
   output logic                          illegal,
   output logic                          step_err,
   output logic                          dir,
   output logic                          locked,
   output logic [ERR_CNT_W-1:0]          err_count
);

   localparam int IDX_W   = $clog2(2*WIDTH);
   localparam int SEQ_LEN = 2*WIDTH;
   localparam int RUN_W   = $clog2(LOCK_CNT + 1);

   state_t               state_q, state_d;
   logic [RUN_W-1:0]     run_q, run_d;
   logic                 seeded_q, seeded_d;
   logic [IDX_W-1:0]     index_q, index_d;
   logic                 dir_q, dir_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;
   logic                 iv_q, iv_d;
   logic                 il_q, il_d;
   logic                 se_q, se_d;

   logic                 dec_legal;
   logic [IDX_W-1:0]     dec_idx;
   logic [IDX_W-1:0]     idx_up;
   logic                 is_up;
   logic                 is_down;
   logic [ERR_CNT_W-1:0] err_inc;

   johnson_code_check #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_check (
      .code_i  (code_in),
      .legal_o (dec_legal),
      .index_o (dec_idx)
   );

   assign idx_up  = (index_q == IDX_W'(SEQ_LEN - 1)) ? '0 : index_q + 1'b1;
   assign is_up   = (dec_idx == idx_up);
   assign err_inc = (err_q == '1) ? err_q : err_q + 1'b1;

`ifdef JOHNSON_DECODER_BIDIR_EN
   logic [IDX_W-1:0] idx_dn;
   assign idx_dn  = (index_q == '0) ? IDX_W'(SEQ_LEN - 1) : index_q - 1'b1;
   assign is_down = (dec_idx == idx_dn);
`else
   assign is_down = 1'b0;
`endif

   // next-state: classify the sample, update run counter, FSM and errors
   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      seeded_d = seeded_q;
      index_d  = index_q;
      dir_d    = dir_q;
      err_d    = err_q;
      iv_d     = 1'b0;
      il_d     = 1'b0;
      se_d     = 1'b0;
      if (code_valid) begin
         if (!dec_legal) begin
            il_d  = 1'b1;
            run_d = '0;
            if (state_q == LOCKED) begin
               state_d  = SEARCH;
               seeded_d = 1'b0;
               err_d    = err_inc;
            end
         end else begin
            index_d = dec_idx;
            iv_d    = 1'b1;
            if (!seeded_q) begin
               // first legal sample only establishes the reference index
               seeded_d = 1'b1;
            end else if (dec_idx != index_q) begin
               if (is_up || is_down) begin
                  dir_d = is_down;
                  if (state_q == SEARCH) begin
                     if (int'(run_q) + 1 >= LOCK_CNT) begin
                        state_d = LOCKED;
                        run_d   = '0;
                     end else begin
                        run_d = run_q + 1'b1;
                     end
                  end
               end else begin
                  se_d  = 1'b1;
                  run_d = '0;
                  if (state_q == LOCKED) begin
                     state_d  = SEARCH;
                     seeded_d = 1'b0;
                     err_d    = err_inc;
                  end
               end
            end
         end
      end
   end

   // state registers with synchronous reset dominating code_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SEARCH;
         run_q    <= '0;
         seeded_q <= 1'b0;
         index_q  <= '0;
         dir_q    <= 1'b0;
         err_q    <= '0;
         iv_q     <= 1'b0;
         il_q     <= 1'b0;
         se_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         seeded_q <= seeded_d;
         index_q  <= index_d;
         dir_q    <= dir_d;
         err_q    <= err_d;
         iv_q     <= iv_d;
         il_q     <= il_d;
         se_q     <= se_d;
      end
   end

   assign index       = index_q;
   assign index_valid = iv_q;
   assign illegal     = il_q;
   assign step_err    = se_q;
   assign dir         = dir_q;
   assign locked      = (state_q == LOCKED);
   assign err_count   = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (WIDTH=8, LOCK_CNT=4).
// Observed vector layout: {index[3:0], index_valid, illegal, step_err,
// dir, locked, err_count[7:0]}.
module tb_johnson_decoder;

   logic       clk;
   logic       rst;
   logic [7:0] code_in;
   logic       code_valid;
   logic [3:0] index;
   logic       index_valid;
   logic       illegal;
   logic       step_err;
   logic       dir;
   logic       locked;
   logic [7:0] err_count;

   logic [16:0] obs;
   int          pass_cnt;
   int          total_cnt;

   johnson_decoder #(
      .WIDTH    (8),
      .LOCK_CNT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .code_in     (code_in),
      .code_valid  (code_valid),
      .index       (index),
      .index_valid (index_valid),
      .illegal     (illegal),
      .step_err    (step_err),
      .dir         (dir),
      .locked      (locked),
      .err_count   (err_count)
   );

   assign obs = {index, index_valid, illegal, step_err, dir, locked, err_count};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] mk(input int idx, input logic iv, input logic il,
                                      input logic se, input logic dr, input logic lk,
                                      input int ec);
      return {4'(idx), iv, il, se, dr, lk, 8'(ec)};
   endfunction

   task automatic step(input logic [7:0] c, input logic v);
      code_in    = c;
      code_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(8'h00, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [16:0] e;
      rst = 1'b1;
      step(8'h0F, 1'b1);
      step(8'h0F, 1'b1);
      e = mk(0, 0, 0, 0, 0, 0, 0);
      total_cnt++;
      if (obs !== e) $display("FAIL reset actual=%h required=%h", obs, e);
      else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_lock_up();
      logic [7:0]  c [7];
      logic        v [7];
      logic [16:0] e [7];
      do_reset();
      c = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F, 8'h55};
      v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      e = '{mk(0,1,0,0,0,0,0), mk(1,1,0,0,0,0,0), mk(2,1,0,0,0,0,0),
            mk(3,1,0,0,0,0,0), mk(4,1,0,0,0,1,0), mk(4,1,0,0,0,1,0),
            mk(4,0,0,0,0,1,0)};
      for (int i = 0; i < 7; i++) begin
         step(c[i], v[i]);
         total_cnt++;
         if (obs !== e[i]) $display("FAIL lock_up[%0d] actual=%h required=%h", i, obs, e[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap();
      logic [7:0]  c [6];
      logic [16:0] e [6];
      do_reset();
      c = '{8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
      e = '{mk(11,1,0,0,0,0,0), mk(12,1,0,0,0,0,0), mk(13,1,0,0,0,0,0),
            mk(14,1,0,0,0,0,0), mk(15,1,0,0,0,1,0), mk(0,1,0,0,0,1,0)};
      for (int i = 0; i < 6; i++) begin
         step(c[i], 1'b1);
         total_cnt++;
         if (obs !== e[i]) $display("FAIL wrap[%0d] actual=%h required=%h", i, obs, e[i]);
         else pass_cnt++;
      end
   endtask

   // continues from test_wrap: locked at index 0
   task automatic test_illegal();
      logic [7:0]  c [5];
      logic        v [5];
      logic [16:0] e [5];
      c = '{8'h05, 8'hFF, 8'h01, 8'h55, 8'h00};
      v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      e = '{mk(0,0,1,0,0,0,1), mk(8,1,0,0,0,0,1), mk(1,1,0,1,0,0,1),
            mk(1,0,1,0,0,0,1), mk(1,0,0,0,0,0,1)};
      for (int i = 0; i < 5; i++) begin
         step(c[i], v[i]);
         total_cnt++;
         if (obs !== e[i]) $display("FAIL illegal[%0d] actual=%h required=%h", i, obs, e[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_down();
      logic [7:0]  c [10];
      logic [16:0] e [10];
      do_reset();
      c = '{8'h80, 8'h00, 8'h01, 8'h03, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80, 8'h00};
`ifdef JOHNSON_DECODER_BIDIR_EN
      e = '{mk(15,1,0,0,0,0,0), mk(0,1,0,0,0,0,0), mk(1,1,0,0,0,0,0),
            mk(2,1,0,0,0,0,0), mk(3,1,0,0,0,1,0), mk(2,1,0,0,1,1,0),
            mk(1,1,0,0,1,1,0), mk(0,1,0,0,1,1,0), mk(15,1,0,0,1,1,0),
            mk(0,1,0,0,0,1,0)};
`else
      e = '{mk(15,1,0,0,0,0,0), mk(0,1,0,0,0,0,0), mk(1,1,0,0,0,0,0),
            mk(2,1,0,0,0,0,0), mk(3,1,0,0,0,1,0), mk(2,1,0,1,0,0,1),
            mk(1,1,0,0,0,0,1), mk(0,1,0,1,0,0,1), mk(15,1,0,1,0,0,1),
            mk(0,1,0,0,0,0,1)};
`endif
      for (int i = 0; i < 10; i++) begin
         step(c[i], 1'b1);
         total_cnt++;
         if (obs !== e[i]) $display("FAIL down[%0d] actual=%h required=%h", i, obs, e[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step(8'h00, 1'b1);
         step(8'h01, 1'b1);
         step(8'h03, 1'b1);
         step(8'h07, 1'b1);
         step(8'h0F, 1'b1);
         step(8'h05, 1'b1);
         if (i == 253) begin
            total_cnt++;
            if (err_count !== 8'd254)
               $display("FAIL sat_pre actual=%0d required=254", err_count);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (err_count !== 8'd255) $display("FAIL sat_end actual=%0d required=255", err_count);
      else pass_cnt++;
   endtask

   // continues from test_saturate: SEARCH, unseeded, err_count=255
   task automatic test_reset_mid_lock();
      logic [16:0] e;
      step(8'h00, 1'b1);
      step(8'h01, 1'b1);
      step(8'h03, 1'b1);
      step(8'h07, 1'b1);
      step(8'h0F, 1'b1);
      e = mk(4, 1, 0, 0, 0, 1, 255);
      total_cnt++;
      if (obs !== e) $display("FAIL rst_pre actual=%h required=%h", obs, e);
      else pass_cnt++;
      rst = 1'b1;
      step(8'h1F, 1'b1);
      e = mk(0, 0, 0, 0, 0, 0, 0);
      total_cnt++;
      if (obs !== e) $display("FAIL rst_mid actual=%h required=%h", obs, e);
      else pass_cnt++;
      rst = 1'b0;
      step(8'h1F, 1'b1);
      e = mk(5, 1, 0, 0, 0, 0, 0);
      total_cnt++;
      if (obs !== e) $display("FAIL rst_seed actual=%h required=%h", obs, e);
      else pass_cnt++;
      step(8'h3F, 1'b1);
      e = mk(6, 1, 0, 0, 0, 0, 0);
      total_cnt++;
      if (obs !== e) $display("FAIL rst_step actual=%h required=%h", obs, e);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt   = 0;
      total_cnt  = 0;
      rst        = 1'b1;
      code_in    = 8'h00;
      code_valid = 1'b0;
      test_reset();
      test_lock_up();
      test_wrap();
      test_illegal();
      test_down();
      test_saturate();
      test_reset_mid_lock();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
